// File: rtl/mult_unit_if.sv
// Execute-stage multiplier interface: request/control from the pipeline,
// product-valid, busy and the HI/LO pair back to it.
interface mult_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             advanceE;
  logic             flushE;
  logic             mthiE;
  logic             mtloE;
  logic             prodv;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, signedE, srcaE, srcbE, advanceE, flushE, mthiE, mtloE,
    input  prodv, busy, hi, lo
  );

  modport slave (
    input  startE, signedE, srcaE, srcbE, advanceE, flushE, mthiE, mtloE,
    output prodv, busy, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for mult/multu, owning the HI/LO pair.
// Signed operands are reduced to magnitudes and the sign is reapplied at the end.
// Optional feature: define MULT_EARLY_TERM_EN to leave BUSY as soon as the
// remaining multiplier bits are all zero.
module mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic        clk,
  input logic        reset,
  mult_unit_if.slave mulIf
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [2*WIDTH-1:0] mcandQ, mcandD;
  logic [WIDTH-1:0]   mplierQ, mplierD;
  logic               negQ, negD;
  logic [WIDTH-1:0]   hiQ, hiD;
  logic [WIDTH-1:0]   loQ, loD;

  logic [WIDTH-1:0]   magA, magB;
  logic [2*WIDTH-1:0] prod;
  logic               lastStep;

  // Operand magnitudes; 0x8000_0000 negates to itself and is read as unsigned.
  always_comb begin
    magA = (mulIf.signedE && mulIf.srcaE[WIDTH-1]) ? ('0 - mulIf.srcaE) : mulIf.srcaE;
    magB = (mulIf.signedE && mulIf.srcbE[WIDTH-1]) ? ('0 - mulIf.srcbE) : mulIf.srcbE;
    prod = negQ ? ('0 - accQ) : accQ;
  end

  // Decide whether the current BUSY step is the final one.
  always_comb begin
    lastStep = (cntQ == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
    if (mplierQ[WIDTH-1:1] == '0) begin
      lastStep = 1'b1;
    end
`endif
  end

  // Next-state and datapath update for the multiply sequencer and HI/LO.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    accD    = accQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    negD    = negQ;
    hiD     = hiQ;
    loD     = loQ;
    unique case (stateQ)
      StIdle: begin
        // Moves take precedence over a simultaneous multiply request.
        if (mulIf.mthiE || mulIf.mtloE) begin
          if (mulIf.mthiE) hiD = mulIf.srcaE;
          if (mulIf.mtloE) loD = mulIf.srcaE;
        end else if (mulIf.startE && !mulIf.flushE) begin
          stateD  = StBusy;
          mcandD  = {{WIDTH{1'b0}}, magA};
          mplierD = magB;
          negD    = mulIf.signedE & (mulIf.srcaE[WIDTH-1] ^ mulIf.srcbE[WIDTH-1]);
          cntD    = '0;
          accD    = '0;
        end
      end
      StBusy: begin
        if (mulIf.flushE) begin
          stateD = StIdle;
        end else begin
          if (mplierQ[0]) accD = accQ + mcandQ;
          mcandD  = mcandQ << 1;
          mplierD = mplierQ >> 1;
          cntD    = cntQ + 1'b1;
          if (lastStep) stateD = StDone;
        end
      end
      StDone: begin
        // Flush beats advance: a squashed multiply never touches HI/LO.
        if (mulIf.flushE) begin
          stateD = StIdle;
        end else if (mulIf.advanceE) begin
          hiD    = prod[2*WIDTH-1:WIDTH];
          loD    = prod[WIDTH-1:0];
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      negQ    <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      accQ    <= accD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      negQ    <= negD;
      hiQ     <= hiD;
      loQ     <= loD;
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    mulIf.prodv = (stateQ == StDone);
    mulIf.busy  = (stateQ != StIdle);
    mulIf.hi    = hiQ;
    mulIf.lo    = loQ;
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: a cycle-level behavioural model compared
// every negedge, plus hand-computed literal results for directed vectors.
module tb_mult_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(32)) mulIf ();

  mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .mulIf (mulIf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: arithmetic product and a BUSY-cycle budget per operation.
  function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int busy_cycles(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int n;
    mag = (s && b[31]) ? (32'd0 - b) : b;
    n = 32;
`ifdef MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
`endif
    return n;
  endfunction

  int          mPhase = 0;  // 0 idle, 1 computing, 2 result held
  int          mLeft = 0;
  logic [63:0] mProd = '0;
  logic [31:0] mHi = '0, mLo = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPhase <= 0;
      mLeft  <= 0;
      mProd  <= '0;
      mHi    <= '0;
      mLo    <= '0;
    end else begin
      case (mPhase)
        0: begin
          if (mulIf.mthiE || mulIf.mtloE) begin
            if (mulIf.mthiE) mHi <= mulIf.srcaE;
            if (mulIf.mtloE) mLo <= mulIf.srcaE;
          end else if (mulIf.startE && !mulIf.flushE) begin
            mPhase <= 1;
            mLeft  <= busy_cycles(mulIf.srcbE, mulIf.signedE);
            mProd  <= model_product(mulIf.srcaE, mulIf.srcbE, mulIf.signedE);
          end
        end
        1: begin
          if (mulIf.flushE) mPhase <= 0;
          else begin
            mLeft <= mLeft - 1;
            if (mLeft == 1) mPhase <= 2;
          end
        end
        default: begin
          if (mulIf.flushE) mPhase <= 0;
          else if (mulIf.advanceE) begin
            mHi    <= mProd[63:32];
            mLo    <= mProd[31:0];
            mPhase <= 0;
          end
        end
      endcase
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy", 64'(mulIf.busy), 64'(mPhase != 0));
    chk("prodv", 64'(mulIf.prodv), 64'(mPhase == 2));
    chk("hi", 64'(mulIf.hi), 64'(mHi));
    chk("lo", 64'(mulIf.lo), 64'(mLo));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for prodv, counting cycles spent busy without a product.
  task automatic wait_prodv(input string name, output int n);
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (mulIf.prodv) begin
        seen = 1;
        break;
      end
      if (mulIf.busy) n++;
      tick();
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_prodv required=prodv", name);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    mulIf.srcaE   = a;
    mulIf.srcbE   = b;
    mulIf.signedE = s;
    mulIf.startE  = 1'b1;
    tick();
  endtask

  task automatic advance_op();
    mulIf.advanceE = 1'b1;
    mulIf.startE   = 1'b0;
    tick();
    mulIf.advanceE = 1'b0;
  endtask

  int n;

  initial begin
    reset          = 1'b1;
    mulIf.startE   = 1'b0;
    mulIf.signedE  = 1'b0;
    mulIf.srcaE    = '0;
    mulIf.srcbE    = '0;
    mulIf.advanceE = 1'b0;
    mulIf.flushE   = 1'b0;
    mulIf.mthiE    = 1'b0;
    mulIf.mtloE    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_prodv", 64'(mulIf.prodv), 64'd0);
    chk("rst_busy", 64'(mulIf.busy), 64'd0);
    chk("rst_hi", 64'(mulIf.hi), 64'd0);
    chk("rst_lo", 64'(mulIf.lo), 64'd0);

    // mthi in IDLE
    mulIf.srcaE = 32'h1234;
    mulIf.mthiE = 1'b1;
    tick();
    mulIf.mthiE = 1'b0;
    chk("mthi_hi", 64'(mulIf.hi), 64'h1234);

    // multu all-ones squared: fixed 32 BUSY cycles in both builds
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_prodv("multu_ff", n);
    chk("multu_ff_cycles", 64'(n), 64'd32);
    advance_op();
    chk("multu_ff_hi", 64'(mulIf.hi), 64'hFFFF_FFFE);
    chk("multu_ff_lo", 64'(mulIf.lo), 64'h0000_0001);
    chk("model_ff_hi", 64'(mHi), 64'hFFFF_FFFE);

    // mult -7*3, then hold DONE for 5 cycles without advance
    start_op(32'hFFFF_FFF9, 32'd3, 1'b1);
    wait_prodv("mult_m7x3", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_prodv", 64'(mulIf.prodv), 64'd1);
      chk("hold_hi", 64'(mulIf.hi), 64'hFFFF_FFFE);
      chk("hold_lo", 64'(mulIf.lo), 64'h0000_0001);
    end
    advance_op();
    chk("mult_m7x3_hi", 64'(mulIf.hi), 64'hFFFF_FFFF);
    chk("mult_m7x3_lo", 64'(mulIf.lo), 64'hFFFF_FFEB);
    chk("model_m7x3_lo", 64'(mLo), 64'hFFFF_FFEB);

    // mult -2^31 * -2^31
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_prodv("mult_min", n);
    advance_op();
    chk("mult_min_hi", 64'(mulIf.hi), 64'h4000_0000);
    chk("mult_min_lo", 64'(mulIf.lo), 64'h0);

    // flush in BUSY cycle 10
    start_op(32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    repeat (9) tick();
    chk("pre_flush_busy", 64'(mulIf.busy), 64'd1);
    mulIf.flushE = 1'b1;
    mulIf.startE = 1'b0;
    tick();
    mulIf.flushE = 1'b0;
    chk("flush_busy", 64'(mulIf.busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_prodv", 64'(mulIf.prodv), 64'd0);
      tick();
    end
    chk("flush_hi", 64'(mulIf.hi), 64'h4000_0000);
    chk("flush_lo", 64'(mulIf.lo), 64'h0);

    // multu 0x8000_0000*2 with an mtlo attempt while BUSY
    start_op(32'h8000_0000, 32'd2, 1'b0);
    mulIf.mtloE = 1'b1;
    mulIf.srcaE = 32'hDEAD;
    tick();
    mulIf.mtloE = 1'b0;
    mulIf.srcaE = 32'h8000_0000;
    wait_prodv("multu_big", n);
    advance_op();
    chk("multu_big_hi", 64'(mulIf.hi), 64'h1);
    chk("multu_big_lo", 64'(mulIf.lo), 64'h0);

    // multu 5*2
    start_op(32'd5, 32'd2, 1'b0);
    wait_prodv("multu_5x2", n);
`ifdef MULT_EARLY_TERM_EN
    chk("multu_5x2_cycles", 64'(n), 64'd2);
`else
    chk("multu_5x2_cycles", 64'(n), 64'd32);
`endif
    advance_op();
    chk("multu_5x2_hi", 64'(mulIf.hi), 64'h0);
    chk("multu_5x2_lo", 64'(mulIf.lo), 64'hA);

    // asynchronous reset mid-BUSY, observed before the next clock edge
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("arst_prodv", 64'(mulIf.prodv), 64'd0);
    chk("arst_busy", 64'(mulIf.busy), 64'd0);
    chk("arst_hi", 64'(mulIf.hi), 64'd0);
    chk("arst_lo", 64'(mulIf.lo), 64'd0);
    mulIf.startE = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
